execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, sequenced by a small state machine and attached beside the execute-stage ALU. It accepts one operation per start pulse and computes it bit-serially: one bit per cycle for normal operands, and a single cycle for divide special cases. While it works it holds the execute stage through its stall request. It then presents a registered 32-bit result with a one-cycle done pulse.

---
 rtl/execute_muldiv.sv | 171 +++++++++++++++++
 tb/tb_execute_muldiv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// One bit per cycle; divide special cases resolve in a single cycle.
module execute_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       function_select,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem;

  logic             accept, last;
  logic             sa_op, sb_op;
  logic             in_sa, in_sb;
  logic [WIDTH-1:0] in_am, in_bm;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] spec_res;

  assign accept = (state == IDLE) && start && !kill;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = accept || (state == CALC);
  assign done   = (state == DONE);

  // Operand decode at acceptance
  always_comb begin
    sa_op = 1'b0;
    sb_op = 1'b0;
    unique case (function_select)
      3'd1, 3'd4, 3'd6: begin
        sa_op = 1'b1;
        sb_op = 1'b1;
      end
      3'd2:    sa_op = 1'b1;
      default: ;
    endcase
  end

  assign in_sa = sa_op && operand_a[WIDTH-1];
  assign in_sb = sb_op && operand_b[WIDTH-1];
  assign in_am = in_sa ? -operand_a : operand_a;
  assign in_bm = in_sb ? -operand_b : operand_b;

  assign div_zero = function_select[2] && (operand_b == '0);
  assign div_ovf  = function_select[2] && !function_select[0]
                  && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                  && (&operand_b);
  assign special  = div_zero || div_ovf;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero: spec_res = function_select[1] ? operand_a : '1;
      div_ovf:  spec_res = function_select[1] ? '0 : operand_a;
      default:  ;
    endcase
  end

  // One iteration step: shift-add multiply, restoring divide
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       shifted, diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0]   prod_nxt;

  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + (prod[0] ? {1'b0, a_mag} : '0);
  assign mul_nxt = {mul_sum, prod[WIDTH-1:1]};

  assign shifted = {rem, prod[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign q_bit   = !diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {prod[WIDTH-2:0], q_bit};

  assign prod_nxt = op[2] ? {prod[2*WIDTH-1:WIDTH], quo_nxt} : mul_nxt;

  logic                 neg;
  logic [2*WIDTH-1:0]   prod_fin;
  logic [WIDTH-1:0]     quo_fin, rem_fin, calc_res;

  assign neg      = sign_a ^ sign_b;
  assign prod_fin = neg ? -mul_nxt : mul_nxt;
  assign quo_fin  = neg ? -quo_nxt : quo_nxt;
  assign rem_fin  = sign_a ? -rem_nxt : rem_nxt;

  always_comb begin
    calc_res = quo_fin;
    unique case (1'b1)
      !op[2] && (op[1:0] == 2'd0): calc_res = prod_fin[WIDTH-1:0];
      !op[2] && (op[1:0] != 2'd0): calc_res = prod_fin[2*WIDTH-1:WIDTH];
      op[2] && op[1]:              calc_res = rem_fin;
      default:                     calc_res = quo_fin;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (kill)      state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Divide keeps the dividend in prod's low half and shifts quotient in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      prod   <= '0;
      rem    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op     <= function_select;
      sign_a <= in_sa;
      sign_b <= in_sb;
      a_mag  <= in_am;
      b_mag  <= in_bm;
      prod   <= {{WIDTH{1'b0}}, function_select[2] ? in_am : in_bm};
      rem    <= '0;
      if (special) result <= spec_res;
    end else if (state == CALC && !kill) begin
      cnt  <= cnt + 1'b1;
      prod <= prod_nxt;
      rem  <= rem_nxt;
      if (last) result <= calc_res;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboarded random/directed bench for execute_muldiv.
// Expected results come from a 64-bit arithmetic reference model.
module tb_execute_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  function_select;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  execute_muldiv #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .function_select (function_select),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .kill            (kill),
    .busy            (busy),
    .done            (done),
    .result          (result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  fs;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned uu;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin uu = ua * ub; return uu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL result fs=%0d got %h @%0d want %h @%0d",
                   e.fs, result, cyc, e.res, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Issue in the current cycle; returns at T+1 with start dropped
  task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want,
                          output int lat);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    function_select = f;
    operand_a = a;
    operand_b = b;
    lat = latency(f, a, b);
    e.res = want;
    e.cyc = cyc + lat;
    e.fs  = f;
    sb_q.push_back(e);
    @(negedge clk);
    check("busy_at_accept", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    function_select = 3'($urandom);
  endtask

  task automatic wait_done(input int lat);
    int  nbusy = 0;
    bit  seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nbusy++;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("busy_cycles", nbusy, (lat == 1) ? 0 : 32);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want);
    int lat;
    start_op(f, a, b, want, lat);
    last_exp = want;
    wait_done(lat);
  endtask

  task automatic run_rand(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    run_op(f, a, b, ref_model(f, a, b));
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    logic [2:0]  f;
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    function_select = '0;
    operand_a = '0;
    operand_b = '0;
    #12;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'd3, 32'h7, 32'hFFFF_FFFD, 32'h0000_0006);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Kill at T+10 of a DIVU
    start_op(3'd5, 32'd1000, 32'd3, 32'd333, lat);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_done", {31'b0, done}, 32'd0);
    check("kill_result", result, last_exp);
    run_op(3'd5, 32'd1000, 32'd3, 32'd333);
    repeat (3) @(negedge clk);
    check("post_result_held", result, 32'd333);

    // Asynchronous reset mid-CALC
    start_op(3'd0, 32'd9, 32'd9, 32'd81, lat);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_rand(f, a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
